// File: rtl/cache_ctl_wb.sv
// Cache controller FSM: multi-word line refill, dirty-victim write-back or write-through,
// and a saturating miss counter. Outputs decode state and inputs combinationally.
module cache_ctl_wb #(
  parameter int WORDS_PER_LINE = 4,
  parameter bit WRITE_BACK     = 1'b1,
  parameter int CNT_W          = 16,
  parameter int BEAT_W         = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic              hit,
  input  logic              dirty,
  input  logic              mem_ack,
  output logic              stall,
  output logic              cache_re,
  output logic              cache_we,
  output logic              fill_we,
  output logic [BEAT_W-1:0] beat,
  output logic              victim_sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic              set_dirty,
  output logic              clr_dirty,
  output logic [CNT_W-1:0]  miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WB   = 3'd1,
    S_FILL = 3'd2,
    S_DONE = 3'd3,
    S_WT   = 3'd4
  } state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t              r_state;
  logic [BEAT_W-1:0]   r_beat;
  logic [CNT_W-1:0]    r_miss_cnt;
  logic                r_wt_done;
  logic                w_req;
  logic                w_last;

  assign w_req    = cpu_read | cpu_write;
  assign w_last   = (r_beat == LAST_BEAT);
  assign miss_cnt = r_miss_cnt;

  // r_wt_done marks the IDLE cycle right after a write-through store, where the
  // CPU still holds the store it has just been released from and must not restart it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_beat     <= {BEAT_W{1'b0}};
      r_miss_cnt <= {CNT_W{1'b0}};
      r_wt_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wt_done <= 1'b0;
          if (!r_wt_done && w_req) begin
            if (!hit) begin
              if (r_miss_cnt != CNT_MAX) begin
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
              end
              r_state <= (WRITE_BACK && dirty) ? S_WB : S_FILL;
            end else if (cpu_write && !WRITE_BACK) begin
              r_state <= S_WT;
            end
          end
        end
        S_WB: begin
          if (mem_ack) begin
            if (w_last) begin
              r_beat  <= {BEAT_W{1'b0}};
              r_state <= S_FILL;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            if (w_last) begin
              r_beat  <= {BEAT_W{1'b0}};
              r_state <= S_DONE;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_WT: begin
          if (mem_ack) begin
            r_wt_done <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode; stall on a miss must rise in the same cycle the miss is seen.
  always_comb begin
    stall      = 1'b0;
    cache_re   = 1'b0;
    cache_we   = 1'b0;
    fill_we    = 1'b0;
    beat       = {BEAT_W{1'b0}};
    victim_sel = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    set_dirty  = 1'b0;
    clr_dirty  = 1'b0;
    case (r_state)
      S_IDLE: begin
        cache_re = w_req;
        if (r_wt_done || !w_req) begin
          stall = 1'b0;
        end else if (!hit) begin
          stall = 1'b1;
        end else if (cpu_write) begin
          cache_we = 1'b1;
          if (WRITE_BACK) begin
            set_dirty = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end else begin
          stall = 1'b0;
        end
      end
      S_WB: begin
        stall      = 1'b1;
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        victim_sel = 1'b1;
        beat       = r_beat;
      end
      S_FILL: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        beat      = r_beat;
        fill_we   = mem_ack;
        clr_dirty = mem_ack & w_last;
      end
      S_DONE: begin
        stall    = 1'b1;
        cache_re = 1'b1;
      end
      S_WT: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_ctl_wb.sv
// Directed bench for cache_ctl_wb: vector table on the default write-back configuration,
// plus hand-written sequences for write-through, mid-burst reset, 1-word lines and saturation.
module tb_cache_ctl_wb;

  logic clk, rst;
  logic cpu_read, cpu_write, hit, dirty, mem_ack;

  int n_chk = 0;
  int n_err = 0;

  // DUT A: WPL=4, write-back, 16-bit counter
  logic stall_a, re_a, we_a, fwe_a, vsel_a, mreq_a, mwe_a, sd_a, cd_a;
  logic [1:0]  beat_a;
  logic [15:0] cnt_a;
  // DUT B: WPL=4, write-through
  logic stall_b, re_b, we_b, fwe_b, vsel_b, mreq_b, mwe_b, sd_b, cd_b;
  logic [1:0]  beat_b;
  logic [15:0] cnt_b;
  // DUT C: WPL=4, write-back, 2-bit counter
  logic stall_c, re_c, we_c, fwe_c, vsel_c, mreq_c, mwe_c, sd_c, cd_c;
  logic [1:0]  beat_c;
  logic [1:0]  cnt_c;
  // DUT D: WPL=1, write-back
  logic stall_d, re_d, we_d, fwe_d, vsel_d, mreq_d, mwe_d, sd_d, cd_d;
  logic [0:0]  beat_d;
  logic [15:0] cnt_d;

  cache_ctl_wb #(.WORDS_PER_LINE(4), .WRITE_BACK(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .hit(hit), .dirty(dirty),
    .mem_ack(mem_ack), .stall(stall_a), .cache_re(re_a), .cache_we(we_a), .fill_we(fwe_a),
    .beat(beat_a), .victim_sel(vsel_a), .mem_req(mreq_a), .mem_we(mwe_a), .set_dirty(sd_a),
    .clr_dirty(cd_a), .miss_cnt(cnt_a));

  cache_ctl_wb #(.WORDS_PER_LINE(4), .WRITE_BACK(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .hit(hit), .dirty(dirty),
    .mem_ack(mem_ack), .stall(stall_b), .cache_re(re_b), .cache_we(we_b), .fill_we(fwe_b),
    .beat(beat_b), .victim_sel(vsel_b), .mem_req(mreq_b), .mem_we(mwe_b), .set_dirty(sd_b),
    .clr_dirty(cd_b), .miss_cnt(cnt_b));

  cache_ctl_wb #(.WORDS_PER_LINE(4), .WRITE_BACK(1'b1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .hit(hit), .dirty(dirty),
    .mem_ack(mem_ack), .stall(stall_c), .cache_re(re_c), .cache_we(we_c), .fill_we(fwe_c),
    .beat(beat_c), .victim_sel(vsel_c), .mem_req(mreq_c), .mem_we(mwe_c), .set_dirty(sd_c),
    .clr_dirty(cd_c), .miss_cnt(cnt_c));

  cache_ctl_wb #(.WORDS_PER_LINE(1), .WRITE_BACK(1'b1), .CNT_W(16)) u_d (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .hit(hit), .dirty(dirty),
    .mem_ack(mem_ack), .stall(stall_d), .cache_re(re_d), .cache_we(we_d), .fill_we(fwe_d),
    .beat(beat_d), .victim_sel(vsel_d), .mem_req(mreq_d), .mem_we(mwe_d), .set_dirty(sd_d),
    .clr_dirty(cd_d), .miss_cnt(cnt_d));

  wire [26:0] obs_a = {stall_a, re_a, we_a, fwe_a, vsel_a, mreq_a, mwe_a, sd_a, cd_a, beat_a, cnt_a};

  // in = {rd, wr, hit, dirty, ack}; fl = {stall, re, we, fill_we, victim, req, mem_we, set_d, clr_d}
  typedef struct {
    logic [4:0]  in;
    logic [8:0]  fl;
    logic [1:0]  bt;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [4:0] in, input logic [8:0] fl, input logic [1:0] bt,
                     input logic [15:0] cnt);
    vec_t v;
    v.in = in; v.fl = fl; v.bt = bt; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] in);
    {cpu_read, cpu_write, hit, dirty, mem_ack} = in;
  endtask

  // Leaves the bench at posedge+1 with reset released and all inputs idle.
  task automatic do_reset();
    set_in(5'b00000);
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_in(5'b00000);
    @(posedge clk);
    #1;
    chk("reset_state", {5'b0, obs_a}, 32'h0);
    rst = 1'b0;

    // read hit then write hit (and both strobes high = store)
    add(5'b10100, 9'b010000000, 2'd0, 16'd0);
    add(5'b01100, 9'b011000010, 2'd0, 16'd0);
    add(5'b00001, 9'b000000000, 2'd0, 16'd0);
    // clean read miss, ack every cycle
    add(5'b10000, 9'b110000000, 2'd0, 16'd0);
    for (int b = 0; b < 4; b++)
      add(5'b10001, (b == 3) ? 9'b100101001 : 9'b100101000, 2'(b), 16'd1);
    add(5'b10100, 9'b110000000, 2'd0, 16'd1);
    add(5'b10100, 9'b010000000, 2'd0, 16'd1);
    // dirty read miss, ack every second cycle
    add(5'b10010, 9'b110000000, 2'd0, 16'd1);
    for (int b = 0; b < 4; b++) begin
      add(5'b10010, 9'b100011100, 2'(b), 16'd2);
      add(5'b10011, 9'b100011100, 2'(b), 16'd2);
    end
    for (int b = 0; b < 4; b++) begin
      add(5'b10010, 9'b100001000, 2'(b), 16'd2);
      add(5'b10011, (b == 3) ? 9'b100101001 : 9'b100101000, 2'(b), 16'd2);
    end
    add(5'b10100, 9'b110000000, 2'd0, 16'd2);
    add(5'b10100, 9'b010000000, 2'd0, 16'd2);
    add(5'b11100, 9'b011000010, 2'd0, 16'd2);
    add(5'b00000, 9'b000000000, 2'd0, 16'd2);

    for (int i = 0; i < vq.size(); i++) begin
      set_in(vq[i].in);
      @(negedge clk);
      chk($sformatf("vec%0d", i), {5'b0, obs_a}, {5'b0, vq[i].fl, vq[i].bt, vq[i].cnt});
      next_cycle();
    end

    // write-through store hit, ack on the third WT cycle
    do_reset();
    set_in(5'b01100);
    @(negedge clk);
    chk("wt_idle", {28'b0, stall_b, we_b, sd_b, mreq_b}, {28'b0, 4'b1100});
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      set_in((i == 2) ? 5'b01101 : 5'b01100);
      @(negedge clk);
      chk($sformatf("wt_mem%0d", i), {25'b0, stall_b, mreq_b, mwe_b, we_b, sd_b, beat_b},
          {25'b0, 7'b1110000});
      next_cycle();
    end
    set_in(5'b01100);
    @(negedge clk);
    chk("wt_release", {28'b0, stall_b, we_b, sd_b, mreq_b}, 32'h0);
    next_cycle();
    set_in(5'b00000);
    @(negedge clk);
    chk("wt_after", {15'b0, stall_b, mreq_b, cnt_b}, 32'h0);
    next_cycle();

    // reset in the middle of a refill at beat 2
    do_reset();
    set_in(5'b10000);
    next_cycle();
    set_in(5'b10001);
    next_cycle();
    next_cycle();
    set_in(5'b10000);
    @(negedge clk);
    chk("mid_fill", {13'b0, stall_a, mreq_a, beat_a, cnt_a}, {13'b0, 1'b1, 1'b1, 2'd2, 16'd1});
    #1;
    set_in(5'b00000);
    rst = 1'b1;
    #1;
    chk("async_rst", {5'b0, obs_a}, 32'h0);
    next_cycle();
    rst = 1'b0;
    set_in(5'b10100);
    @(negedge clk);
    chk("post_rst", {5'b0, obs_a}, {5'b0, 9'b010000000, 2'd0, 16'd0});
    next_cycle();

    // one-word line: dirty miss gives single-beat write-back and refill
    do_reset();
    set_in(5'b10010);
    next_cycle();
    set_in(5'b10011);
    @(negedge clk);
    chk("wpl1_wb", {26'b0, stall_d, mreq_d, mwe_d, vsel_d, fwe_d, beat_d}, {26'b0, 6'b111100});
    next_cycle();
    @(negedge clk);
    chk("wpl1_fill", {26'b0, stall_d, mreq_d, mwe_d, fwe_d, cd_d, beat_d}, {26'b0, 6'b110110});
    next_cycle();
    set_in(5'b10100);
    @(negedge clk);
    chk("wpl1_done", {29'b0, stall_d, re_d, mreq_d}, {29'b0, 3'b110});
    next_cycle();
    @(negedge clk);
    chk("wpl1_idle", {15'b0, stall_d, cnt_d}, {15'b0, 1'b0, 16'd1});
    next_cycle();

    // 2-bit counter saturates at 3
    do_reset();
    for (int m = 0; m < 5; m++) begin
      set_in(5'b10000);
      next_cycle();
      set_in(5'b10001);
      repeat (4) next_cycle();
      set_in(5'b10100);
      @(negedge clk);
      chk($sformatf("sat%0d", m), {29'b0, stall_c, cnt_c}, {29'b0, 1'b1, (m < 3) ? 2'(m + 1) : 2'd3});
      next_cycle();
      next_cycle();
    end
    set_in(5'b00000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_ctl_wb.md
Name: cache_ctl_wb

Overview:
- Parametrised cache controller FSM; successor to the single-word read-miss/stall controller.
- Adds multi-word line refill bursts, dirty-victim write-back, a selectable write-back/write-through policy, and a saturating miss counter.
- Sits between the CPU memory stage (read/write strobes, stall), the cache array (hit/dirty in, write enables out) and the main-memory handshake (req/ack per word beat).

Parameters:
- WORDS_PER_LINE, 4, words per cache line; power of 2, >=1.
- WRITE_BACK, 1, 1 = write-back + write-allocate; 0 = write-through + write-allocate.
- CNT_W, 16, miss counter width.
- BEAT_W, max(1,$clog2(WORDS_PER_LINE)), beat index width (derived).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- cpu_read  in  1  CPU load request, held until stall low.
- cpu_write  in  1  CPU store request, held until stall low.
- hit  in  1  cache tag match for current CPU address.
- dirty  in  1  dirty bit of indexed line.
- mem_ack  in  1  memory accepted/returned one word this cycle.
- stall  out  1  freeze CPU pipeline.
- cache_re  out  1  cache array read enable.
- cache_we  out  1  CPU store data written into cache.
- fill_we  out  1  memory word written into cache at beat.
- beat  out  BEAT_W  word offset of current burst beat.
- victim_sel  out  1  memory address uses victim tag (write-back).
- mem_req  out  1  memory request.
- mem_we  out  1  memory request is a write.
- set_dirty  out  1  mark indexed line dirty.
- clr_dirty  out  1  mark indexed line clean/valid after refill.
- miss_cnt  out  CNT_W  saturating count of misses.

Behaviour:
- Reset (async, rst=1): state IDLE, beat counter 0, miss_cnt 0; all outputs 0 except those derived combinationally from IDLE + inputs; mem_req falls without waiting for clk. Reset mid-burst abandons the burst, with no completion pulse.
- States: IDLE, WB, FILL, DONE, WT.
- req = cpu_read | cpu_write; cpu_write has priority if both are high (treated as store).
- IDLE:
  - cache_re = req.
  - Read hit: stall 0, stay.
  - Write hit, WRITE_BACK=1: cache_we=1, set_dirty=1, stall 0, stay.
  - Write hit, WRITE_BACK=0: cache_we=1, stall=1, next WT.
  - Miss (req & ~hit): stall=1 combinationally the same cycle; miss_cnt+1 (saturate at all-ones); next WB if WRITE_BACK & dirty, else FILL.
- WB:
  - mem_req=1, mem_we=1, victim_sel=1, beat=counter, stall=1.
  - On mem_ack: counter+1.
  - Ack on beat WORDS_PER_LINE-1: counter<=0, next FILL.
- FILL:
  - mem_req=1, mem_we=0, beat=counter, stall=1.
  - fill_we = mem_ack (same cycle).
  - Ack on last beat: clr_dirty=1 that cycle, counter<=0, next DONE.
- DONE: stall=1, cache_re=1 for one cycle (re-lookup); next IDLE. Re-lookup then hits; a store completes in IDLE via the hit path.
- WT:
  - mem_req=1, mem_we=1, beat=0, stall=1.
  - On mem_ack: next IDLE; stall falls the following cycle.
- Handshake:
  - mem_req stays high continuously across beats until the final ack.
  - mem_ack while mem_req=0 is ignored.
  - One beat advances per ack cycle; back-to-back acks give one beat per clock.
- WORDS_PER_LINE=1: each burst is a single beat; beat is constantly 0.
- Minimum read-miss stall (clean victim, ack every cycle) = WORDS_PER_LINE + 2 cycles.
- Miss counter saturates; it does not wrap.

Test Plan:
- Read hit, then write hit (WRITE_BACK=1) -> stall never high; cache_we=1 and set_dirty=1 exactly in the write cycle; miss_cnt=0.
- Read miss, clean line, WPL=4, mem_ack every cycle -> stall high 6 cycles; fill_we on beats 0,1,2,3; clr_dirty with beat 3; miss_cnt=1.
- Read miss, dirty line, WPL=4, ack every 2nd cycle -> 4 WB beats (mem_we=1, victim_sel=1), then 4 FILL beats; mem_req continuous; beat sequence 0..3 twice.
- WRITE_BACK=0, write hit, ack after 3 cycles -> cache_we pulses once; mem_we held 3 cycles; stall drops the cycle after ack; set_dirty never asserted.
- rst asserted mid-FILL at beat 2 -> mem_req/stall fall asynchronously; after release, beat=0, state IDLE, miss_cnt=0.
- CNT_W=2, 5 misses -> miss_cnt reads 1,2,3,3,3.
